// File: rtl/wts_channel_mixer_if.sv
// Channel-register / wave-SRAM / output bus of the wavetable channel mixer.
// The master modport is the mixer; the slave modport is its surroundings.
interface wts_channel_mixer_if;
  logic        [2:0]  ch_select;
  logic        [6:0]  wave_address;
  logic        [3:0]  ch_volume;
  logic               ch_enable;
  logic        [9:0]  sram_address;
  logic               sram_rd;
  logic signed [7:0]  sram_rdata;
  logic signed [10:0] sound_out;
  logic               sound_valid;

  modport master (
    output ch_select, sram_address, sram_rd, sound_out, sound_valid,
    input  wave_address, ch_volume, ch_enable, sram_rdata
  );

  modport slave (
    input  ch_select, sram_address, sram_rd, sound_out, sound_valid,
    output wave_address, ch_volume, ch_enable, sram_rdata
  );
endinterface

// File: rtl/wts_channel_mixer.sv
// Time-multiplexed wavetable mixer: one channel per active pulse, one mixed sample per frame.
// Optional macro WTS_CHANNEL_MASK_EN adds a channel_mask input that mutes channels at capture.
module wts_channel_mixer #(
  parameter int CH_NUM = 6
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                active,
`ifdef WTS_CHANNEL_MASK_EN
  input  logic [CH_NUM-1:0]   channel_mask,
`endif
  wts_channel_mixer_if.master bus
);

  localparam logic [3:0] LAST_SLOT = 4'(CH_NUM);

  logic        [3:0]  ff_slot;
  logic        [3:0]  ff_vol;
  logic               ff_term_valid;
  logic signed [10:0] ff_accum;
  logic signed [10:0] sound_out_q;
  logic               sound_valid_q;

  logic               capture;
  logic               muted;
  logic signed [7:0]  term;
  logic signed [10:0] term_ext;

  // Signed sample times unsigned volume, floored by 16; the result always fits 8 bits.
  function automatic logic signed [7:0] scale_term(input logic signed [7:0] sample,
                                                    input logic        [3:0] vol);
    logic signed [12:0] prod;
    prod = sample * $signed({1'b0, vol});
    return prod[11:4];
  endfunction

`ifdef WTS_CHANNEL_MASK_EN
  logic [7:0] mask_pad;
  assign mask_pad = 8'(channel_mask);
  assign muted    = mask_pad[ff_slot[2:0]];
`else
  assign muted    = 1'b0;
`endif

  assign capture  = (ff_slot < LAST_SLOT);
  assign term     = scale_term(bus.sram_rdata, ff_vol);
  assign term_ext = 11'(term);

  assign bus.ch_select    = ff_slot[2:0];
  assign bus.sram_rd      = capture;
  assign bus.sram_address = {ff_slot[2:0], bus.wave_address};
  assign bus.sound_out    = sound_out_q;
  assign bus.sound_valid  = sound_valid_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ff_slot       <= 4'd0;
      ff_vol        <= 4'd0;
      ff_term_valid <= 1'b0;
      ff_accum      <= '0;
      sound_out_q   <= '0;
      sound_valid_q <= 1'b0;
    end else begin
      sound_valid_q <= 1'b0;
      if (active) begin
        // slot counter
        ff_slot <= (ff_slot == LAST_SLOT) ? 4'd0 : ff_slot + 4'd1;

        // capture stage: latch this slot's volume for the term computed next slot
        if (capture) begin
          ff_vol        <= (bus.ch_enable && !muted) ? bus.ch_volume : 4'd0;
          ff_term_valid <= 1'b1;
        end else begin
          ff_term_valid <= 1'b0;
        end

        // accumulate stage: previous slot's volume and its now-returned sample
        if (ff_slot == LAST_SLOT) begin
          sound_out_q   <= ff_accum + term_ext;
          ff_accum      <= '0;
          sound_valid_q <= 1'b1;
        end else if (ff_slot != 4'd0 && ff_term_valid) begin
          ff_accum <= ff_accum + term_ext;
        end
      end
    end
  end

endmodule

// File: doc/wts_channel_mixer.md
Name: wts_channel_mixer

Overview:
Downstream consumer of the per-channel tone generators' 7-bit wave addresses.
- Time-multiplexes the channels on the 3.579MHz `active` pulse.
- For each channel, reads the wave sample from the shared wave SRAM and scales it by the channel volume.
- Accumulates all channels into one signed mixed sample, emitted once per frame of CH_NUM+1 active pulses.
- Sits between the tone generators / channel registers and the output DAC / filter stage.

Parameters:
CH_NUM, 6, number of channels mixed (legal range 1..8); a frame is CH_NUM+1 active pulses

Ports:
clk  in  1  system clock
nreset  in  1  asynchronous reset, active-low (negative logic)
active  in  1  3.579MHz timing pulse, one clk wide; all state advances only on clk edges where active=1
ch_select  out  3  channel currently addressed; external muxes route that channel's wave_address/volume/enable
wave_address  in  7  wave address of channel ch_select (muxed tone generator output)
ch_volume  in  4  volume of channel ch_select, unsigned 0..15
ch_enable  in  1  key-on of channel ch_select
sram_address  out  10  {ch_select, wave_address}
sram_rd  out  1  1 while slot < CH_NUM (read request level)
sram_rdata  in  8  signed two's-complement sample; must be valid by the next active pulse after the address is presented
sound_out  out  11  signed mixed sample, held between updates
sound_valid  out  1  one-clk pulse when sound_out updates

Behaviour:
Reset (nreset=0, async) forces the following regardless of clk:
- ff_slot (4 bit) = 0.
- ff_vol = 0, ff_term_valid = 0, ff_accum = 0.
- sound_out = 0, sound_valid = 0.
- Resulting outputs: ch_select = 0, sram_rd = 1.

Slot counter:
- On active, ff_slot advances 0,1,…,CH_NUM, then wraps to 0.
- Holds when active=0.

Combinational outputs:
- ch_select = ff_slot[2:0].
- sram_rd = (ff_slot < CH_NUM).
- sram_address = {ff_slot[2:0], wave_address}; stable for the whole slot.

Capture stage (active && ff_slot < CH_NUM):
- ff_vol <= ch_enable ? ch_volume : 0.
- ff_term_valid <= 1.

Capture stage (active && ff_slot == CH_NUM):
- ff_term_valid <= 0.

Term computation:
- term = (signed sram_rdata × unsigned ff_vol) as a 12-bit signed product, arithmetic-shifted right by 4 (floor).
- term range is -120..+119.

Accumulate stage (same active edge, using the previous slot's ff_vol and sram_rdata):
- ff_slot in 1..CH_NUM-1 and ff_term_valid=1: ff_accum <= ff_accum + sign-extended term.
- ff_slot == CH_NUM:
  - sound_out <= ff_accum + term (term from channel CH_NUM-1).
  - ff_accum <= 0.
  - sound_valid <= 1 for exactly one clk.
- ff_slot == 0: ff_term_valid is 0 (set at slot CH_NUM), so nothing is added; ff_accum stays 0.

Arithmetic and timing properties:
- Sum bound: |sum| ≤ 8×120 = 960, so no overflow in 11 bits and no saturation logic is needed.
- Latency: sample read at slot s appears in sound_out at the slot-CH_NUM edge of the same frame.
- Period: sound_valid fires every CH_NUM+1 active pulses. The first pulse after reset comes at the (CH_NUM+1)-th active pulse.

Boundary conditions:
- Volume or enable changes mid-frame take effect from that channel's next capture; an already captured ff_vol is unaffected.
- active held high on consecutive clks: one slot per clk, no special case.
- sound_valid is generated only on an active edge; it is 0 on all other clks.
- Reset mid-frame discards the partial accumulation. sound_out returns to 0 and the next frame starts at slot 0.
- CH_NUM=1: slots 0,1 only; sound_out = term(ch0) every 2 active pulses.

Optional Feature:
Macro `WTS_CHANNEL_MASK_EN`.
- When defined:
  - Adds input port channel_mask [CH_NUM-1:0].
  - At capture, if channel_mask[ff_slot] = 1, ff_vol <= 0 (channel muted). SRAM reads still occur.
- When undefined:
  - The port is absent.
  - Behaviour is exactly as above.

Test Plan:
1. Reset then 7 active pulses, CH_NUM=6, all ch_enable=1, volume=15, sram_rdata=+127 for every read → one sound_valid at pulse 7; sound_out = 6×119 = 714.
2. Same as scenario 1 but sram_rdata=-128 → sound_out = -720; a second frame with unchanged inputs gives a second pulse exactly 7 active pulses later, same value.
3. ch2 ch_enable=0, others volume=8, data=+64 → each enabled term is 32; sound_out = 5×32 = 160; sram_address for slot 2 = {3'd2, wave_address}, sram_rd=1.
4. Assert nreset at slot 3 with ff_accum nonzero → sound_out=0, sound_valid=0, ch_select=0 immediately; the next valid frame equals a clean frame value.
5. active gapped randomly (1 pulse every 1..5 clks) with scenario-1 stimulus → identical sound_out sequence; sound_valid is 1 clk wide and coincides with an active clk.
6. `WTS_CHANNEL_MASK_EN` defined, channel_mask=6'b000011, scenario-1 stimulus → sound_out = 4×119 = 476; sram_rd still asserted for slots 0..5.
